// File: rtl/keypad_pkg.sv
// keypad_pkg: shared states, constants and key classification for the keypad key filter
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_e;
  localparam logic [3:0] COL_FIRST = 4'b0111;
  localparam logic [3:0] ROW_IDLE  = 4'b1111;
  localparam logic [3:0] KEY_CLEAR = 4'h0;
  localparam logic [3:0] DIGIT_MIN = 4'h1;
  localparam logic [3:0] DIGIT_MAX = 4'h9;
  function automatic logic key_is_digit(input logic [3:0] k);
    return (k >= DIGIT_MIN) && (k <= DIGIT_MAX);
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with a configurable asynchronous reset value
module sync_2ff #(
  parameter int             W       = 4,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q, sync_q;
  // metastability stage followed by the stable output stage
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/keypad_key_filter.sv
// keypad_key_filter: frame-based press/release debounce producing one event per key press
module keypad_key_filter
  import keypad_pkg::*;
#(
  parameter int PRESS_SCANS   = 3,
  parameter int RELEASE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  input  logic [3:0] row,
  input  logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] key_out,
  output logic       is_digit,
  output logic       is_clear,
  output logic       key_held
);
  localparam logic [3:0] PRESS_N = 4'(PRESS_SCANS);
  localparam logic [3:0] REL_N   = 4'(RELEASE_SCANS);
  state_e     state_q, state_d;
  logic [3:0] rows_s, col_q, col_qq;
  logic [3:0] cnt_q, cnt_d, cand_q, cand_d, key_out_q, key_out_d, cnt_inc;
  logic       tick_q, act_q, any_row, frame_active;
  logic       key_valid_q, key_valid_d, is_digit_q, is_digit_d, is_clear_q, is_clear_d;
  sync_2ff #(.W(4), .RST_VAL(ROW_IDLE)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row),
    .q_o (rows_s)
  );
  assign any_row      = rows_s != ROW_IDLE;
  assign frame_active = act_q | any_row;
  assign cnt_inc      = cnt_q + 4'd1;
  // tick marks the start of each full scan; activity accumulates over the frame it closes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q  <= ROW_IDLE;
      col_qq <= ROW_IDLE;
      tick_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      col_q  <= col;
      col_qq <= col_q;
      tick_q <= (col_q == COL_FIRST) && (col_qq != COL_FIRST);
      act_q  <= tick_q ? 1'b0 : (act_q | any_row);
    end
  // filter state and the registered event outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_out_q   <= 4'd0;
      is_digit_q  <= 1'b0;
      is_clear_q  <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_out_q   <= key_out_d;
      is_digit_q  <= is_digit_d;
      is_clear_q  <= is_clear_d;
      key_valid_q <= key_valid_d;
    end
  // frame-level decisions, evaluated only on tick
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_out_d   = key_out_q;
    is_digit_d  = is_digit_q;
    is_clear_d  = is_clear_q;
    key_valid_d = 1'b0;
    if (tick_q)
      case (state_q)
        IDLE:
          if (frame_active) begin
            cand_d  = key_code;
            cnt_d   = 4'd1;
            state_d = PRESS_CHK;
          end
        PRESS_CHK:
          if (!frame_active) state_d = IDLE;
          else if (key_code != cand_q) begin
            cand_d = key_code;
            cnt_d  = 4'd1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == PRESS_N) begin
              key_out_d   = cand_q;
              is_digit_d  = key_is_digit(cand_q);
              is_clear_d  = cand_q == KEY_CLEAR;
              key_valid_d = 1'b1;
              state_d     = HELD;
            end
          end
        HELD:
          if (!frame_active) begin
            cnt_d   = 4'd1;
            state_d = REL_CHK;
          end
        REL_CHK:
          if (frame_active) state_d = HELD;
          else begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == REL_N) ? IDLE : REL_CHK;
          end
        default: state_d = IDLE;
      endcase
  end
  assign key_valid = key_valid_q;
  assign key_out   = key_out_q;
  assign is_digit  = is_digit_q;
  assign is_clear  = is_clear_q;
  assign key_held  = (state_q == HELD) || (state_q == REL_CHK);
endmodule

// File: doc/keypad_key_filter.md
Name: keypad_key_filter

Overview:
- Sits directly downstream of the keypad scan decoder.
- Consumes the decoder's column drive, the raw row pins, and the 4-bit held key code. Produces a debounced one-cycle key-press event per physical press, plus the sudoku key class (digit 1-9, clear 0, command A-F).
- Adds the press/release detection the decoder lacks. Repeated presses of the same key each yield one event.

Parameters:
PRESS_SCANS, 3, consecutive active scan frames with an identical key code needed to accept a press (legal range 2..15)
RELEASE_SCANS, 3, consecutive inactive scan frames needed to declare release (legal range 2..15)

Ports:
clk  in  1  100 MHz system clock
rst  in  1  reset; asynchronous, active-high
col  in  4  column drive from the decoder (0111, 1011, 1101, 1110 in scan order)
row  in  4  raw keypad row pins, active-low, asynchronous to clk
key_code  in  4  decoder output; last decoded key, held
key_valid  out  1  one-cycle pulse per accepted press
key_out  out  4  accepted key code; updated together with key_valid, held otherwise
is_digit  out  1  key_out in 1..9; updated with key_out
is_clear  out  1  key_out == 0; updated with key_out
key_held  out  1  high in HELD and REL_CHK states

Behaviour:
- Reset (async, any cycle): all outputs 0; FSM to IDLE; counters 0; col_q = 1111; row synchroniser = 1111; activity flag 0. No pulse may be emitted in flight across reset.
- row passes through a 2-flop synchroniser (rows_s). `any_row = (rows_s != 1111)`.
- Frame tick:
  - col_q is col registered.
  - tick is a registered one-cycle pulse, high the cycle after col_q changes from a value other than 0111 to 0111, i.e. at the start of each full 4-column scan.
  - col staying at 0111 produces no further ticks.
- Activity accumulator:
  - act_acc sets on any cycle with any_row.
  - On tick, frame_active = act_acc | any_row; act_acc then clears.
  - If any_row and tick coincide, that cycle counts toward the ending frame only.
- key_code is sampled on tick only.
- FSM, 4 states; all transitions happen on tick cycles only. cnt is 4 bits, cand is 4 bits.
  - IDLE:
    - active → cand = key_code, cnt = 1, go to PRESS_CHK.
    - inactive → stay.
  - PRESS_CHK:
    - active and key_code == cand → cnt + 1. If cnt + 1 == PRESS_SCANS, register key_out = cand, set is_digit/is_clear, pulse key_valid the next cycle, go to HELD.
    - active and key_code != cand → cand = key_code, cnt = 1, stay.
    - inactive → IDLE with no event.
  - HELD:
    - inactive → cnt = 1, go to REL_CHK.
    - active → stay; no repeat events.
  - REL_CHK:
    - inactive → cnt + 1. If it reaches RELEASE_SCANS, go to IDLE.
    - active → HELD (bounce during release).
- Latency: key_valid is high exactly one clk cycle, the cycle after the qualifying tick. key_out, is_digit and is_clear change in that same cycle.
- Multiple simultaneous keys: the decoder's code wins. A code change mid-qualification restarts the count; no event for the abandoned code.
- No tick ever (decoder stalled): the FSM holds its state indefinitely. This is legal.

Decomposition:
- Package keypad_pkg holds:
  - state encoding (IDLE, PRESS_CHK, HELD, REL_CHK)
  - COL_FIRST = 4'b0111
  - ROW_IDLE = 4'b1111
  - KEY_CLEAR = 4'h0
  - DIGIT_MIN = 4'h1, DIGIT_MAX = 4'h9
- One sub-module: sync_2ff (4-bit wide, async reset value 1111), used for row.

Test Plan:
- Bench setup: drive col in 0111/1011/1101/1110 with 20-cycle slots; PRESS_SCANS=3, RELEASE_SCANS=3.
- Clean press: row=1011 during col 1011 slots, key_code=5, for 4 frames, then release for 4 frames → exactly one key_valid pulse on the cycle after the 3rd tick; key_out=5, is_digit=1, is_clear=0; key_held falls after the 3rd inactive tick.
- Bounce: key active 2 frames, inactive 1, active 1 → no key_valid; FSM back in IDLE, then PRESS_CHK.
- Code change: key_code=7 for 2 active frames, then 0 for 3 active frames → single event with key_out=0, is_clear=1, is_digit=0; no event for 7.
- Repeat press: press 9 (3 frames), release 3 frames, press 9 again → two key_valid pulses. A release of only 1 frame between presses → one pulse.
- Async reset: assert rst mid-PRESS_CHK (cnt=2), then release and keep key active → outputs 0 during reset; an event is emitted only 3 ticks after reset deassertion; no glitch pulse.
- Held key: key_code=E, active 10 frames → one pulse, key_held=1 for the entire hold, is_digit=0, is_clear=0.
